// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM command arbiter.
// Channel heads are carried at a fixed maximum width and trimmed at the top level.
package sdram_arb_pkg;

  localparam int unsigned MaxAddrW = 32;
  localparam int unsigned MaxDataW = 32;

  typedef enum logic [2:0] {
    C_STARVED,
    C_URGENT,
    C_HIT_WR,
    C_HIT_RD,
    C_NEW_WR,
    C_RD
  } arb_class_e;

  typedef struct packed {
    logic                is_write;
    logic [MaxAddrW-1:0] addr;
    logic [MaxDataW-1:0] data;
  } ch_head_t;

  function automatic logic [MaxAddrW-1:0] row_of(input logic [MaxAddrW-1:0] addr,
                                                 input int unsigned         row_lsb);
    return addr >> row_lsb;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping modulo NCH.
module sdram_rr_pick #(
  parameter int unsigned NCH = 4,
  localparam int unsigned IdxW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned j;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NCH;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// N-channel SDRAM command arbiter: class priority with round-robin inside a class,
// starvation aging, per-channel enables and open-row tracking. Grant path is combinational.
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ROW_LSB       = 10,
  parameter int unsigned USEDW_W       = 8,
  parameter int unsigned URGENT_THRESH = 200,
  parameter int unsigned MAX_WAIT      = 64,
  localparam int unsigned IdxW         = $clog2(NCH),
  localparam int unsigned RowW         = ADDR_W - ROW_LSB,
  localparam int unsigned WaitW        = $clog2(MAX_WAIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH-1:0]          ch_enable,
  input  logic [NCH-1:0]          ch_is_write,
  input  logic [NCH*ADDR_W-1:0]   ch_addr,
  input  logic [NCH*DATA_W-1:0]   ch_data,
  input  logic [NCH*USEDW_W-1:0]  ch_usedw,
  input  logic [NCH-1:0]          ch_urgent_en,
  output logic [NCH-1:0]          ch_pop,
  input  logic                    out_full,
  output logic                    out_write,
  output logic                    out_is_write,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic [IdxW-1:0]         out_ch,
  output logic [RowW-1:0]         present_row,
  output logic                    last_was_write
);

  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [RowW-1:0]  present_row_q, present_row_d;
  logic             lww_q, lww_d;
  logic [WaitW-1:0] wait_q [NCH];
  logic [WaitW-1:0] wait_d [NCH];

  ch_head_t         head [NCH];
  logic [NCH-1:0]   elig;
  logic [NCH-1:0]   class_mask [6];
  logic [NCH-1:0]   sel_mask;
  arb_class_e       cls;
  logic             row_hit;
  logic             pick_valid, grant;
  logic [IdxW-1:0]  pick_idx;

  always_comb begin
    row_hit = 1'b0;
    elig    = ch_valid & ch_enable;
    for (int c = 0; c < 6; c++) class_mask[c] = '0;
    for (int i = 0; i < NCH; i++) begin
      head[i].is_write = ch_is_write[i];
      head[i].addr     = MaxAddrW'(ch_addr[i*ADDR_W +: ADDR_W]);
      head[i].data     = MaxDataW'(ch_data[i*DATA_W +: DATA_W]);
      row_hit = row_of(head[i].addr, ROW_LSB) == MaxAddrW'(present_row_q);
      class_mask[C_STARVED][i] = elig[i] && (wait_q[i] == WaitW'(MAX_WAIT));
      class_mask[C_URGENT][i]  = elig[i] && ch_urgent_en[i] &&
                                 (32'(ch_usedw[i*USEDW_W +: USEDW_W]) > URGENT_THRESH);
      class_mask[C_HIT_WR][i]  = elig[i] && lww_q && ch_is_write[i] && row_hit;
      class_mask[C_HIT_RD][i]  = elig[i] && !ch_is_write[i] && row_hit;
      class_mask[C_NEW_WR][i]  = elig[i] && ch_is_write[i];
      class_mask[C_RD][i]      = elig[i];
    end
  end

  // Highest non-empty class wins; only its members reach the round-robin picker.
  always_comb begin
    cls = C_RD;
    for (int c = 5; c >= 0; c--) begin
      if (|class_mask[c]) cls = arb_class_e'(3'(c));
    end
    sel_mask = class_mask[cls];
  end

  sdram_rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .req_i   (sel_mask),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign grant = pick_valid && !out_full && rst_n;

  always_comb begin
    ch_pop = '0;
    if (grant) ch_pop[pick_idx] = 1'b1;
    out_write    = grant;
    out_is_write = head[pick_idx].is_write;
    out_addr     = ADDR_W'(head[pick_idx].addr);
    out_data     = DATA_W'(head[pick_idx].data);
    out_ch       = pick_idx;
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    present_row_d = present_row_q;
    lww_d         = lww_q;
    if (grant) begin
      rr_ptr_d      = (pick_idx == IdxW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
      present_row_d = RowW'(row_of(head[pick_idx].addr, ROW_LSB));
      lww_d         = head[pick_idx].is_write;
    end
    // Aging keeps running under backpressure so a blocked head still gets promoted.
    for (int i = 0; i < NCH; i++) begin
      if (!elig[i] || (grant && pick_idx == IdxW'(i))) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WaitW'(MAX_WAIT)) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      present_row_q <= '0;
      lww_q         <= 1'b1;
      for (int i = 0; i < NCH; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      present_row_q <= present_row_d;
      lww_q         <= lww_d;
      for (int i = 0; i < NCH; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign present_row    = present_row_q;
  assign last_was_write = lww_q;

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Parametrised N-channel command arbiter that sits between per-port show-ahead command FIFOs and the EasySDRAM command input.
- Generalises the fixed Port0/PortV/PortC priority chain to NCH channels. Each cycle it picks at most one head-of-FIFO command, using a class-based priority with round-robin fairness inside each class.
- Adds behaviour the fixed chain lacks: per-channel starvation aging, per-channel enable masks, and correct tracking of the open row.

Parameters:
NCH, 4, number of request channels (2..8)
ADDR_W, 25, SDRAM word address width
DATA_W, 16, write data width
ROW_LSB, 10, row = addr[ADDR_W-1:ROW_LSB]
USEDW_W, 8, width of each channel FIFO fill level
URGENT_THRESH, 200, channel is urgent when usedw > this
MAX_WAIT, 64, cycles a pending head may wait before it is forced (>=1)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  synchronous reset, active-low
ch_valid  in  NCH  channel FIFO not empty (head valid)
ch_enable  in  NCH  channel participates in arbitration; 0 masks it
ch_is_write  in  NCH  head command type (1=write)
ch_addr  in  NCH*ADDR_W  head addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_data  in  NCH*DATA_W  head write data, packed the same way
ch_usedw  in  NCH*USEDW_W  channel FIFO fill levels
ch_urgent_en  in  NCH  urgency class allowed per channel
ch_pop  out  NCH  one-hot (or zero) read acknowledge to the channel FIFO
out_full  in  1  SDRAM command buffer full
out_write  out  1  command strobe to SDRAM
out_is_write  out  1  granted command type
out_addr  out  ADDR_W  granted address
out_data  out  DATA_W  granted write data
out_ch  out  $clog2(NCH)  granted channel index
present_row  out  ADDR_W-ROW_LSB  row of the last granted command
last_was_write  out  1  type of the last granted command

Behaviour:
- Grant path is combinational. ch_pop[g], out_write and the out_* fields are asserted in the same cycle from head g.
- Channel FIFOs must be show-ahead. Zero-cycle latency, as in the existing port logic.
- A channel is eligible when ch_valid & ch_enable. No grant is made when out_full=1 or rst_n=0. Then ch_pop=0 and out_write=0; out_* fields are don't-care.
- Priority classes, highest first; the first non-empty class wins:
  - C0 starved: wait_cnt[i] == MAX_WAIT.
  - C1 urgent: ch_urgent_en[i] & usedw[i] > URGENT_THRESH.
  - C2 row-hit write: last_was_write & is_write & row == present_row.
  - C3 row-hit read: ~is_write & row == present_row.
  - C4 new-row write: is_write.
  - C5 read: any remaining eligible channel.
- Within a class, round-robin: the first set bit at or after rr_ptr, wrapping modulo NCH.
- On every grant: rr_ptr <= (g+1) mod NCH (NCH not a power of 2 must wrap correctly), present_row <= row of g, last_was_write <= is_write of g.
- Per-channel wait_cnt ($clog2(MAX_WAIT+1) bits):
  - cleared when the channel is granted or not eligible;
  - otherwise +1, saturating at MAX_WAIT;
  - still counts while out_full=1.
- Simultaneous starvation on several channels: C0 round-robin applies. Starved channels are served before urgent ones.
- Reset (synchronous, rst_n low at a clk edge): rr_ptr=0, present_row=0, last_was_write=1, all wait_cnt=0.
- Reset asserted mid-operation: state reloads on that edge. While rst_n=0, ch_pop and out_write are forced to 0 combinationally.
- A channel whose ch_enable drops while it holds wait_cnt has the counter cleared next cycle.

Decomposition:
- Package sdram_arb_pkg holds:
  - typedef enum arb_class_e {C_STARVED, C_URGENT, C_HIT_WR, C_HIT_RD, C_NEW_WR, C_RD};
  - a typedef struct for a channel head (is_write, addr, data);
  - the function row_of(addr).
- One sub-module, sdram_rr_pick: inputs a NCH-bit request mask and rr_ptr; outputs a valid flag and the index. One instance per class, or one instance fed by the selected class mask.

Test Plan:
- Reset: rst_n=0 for 3 cycles with all ch_valid=1 -> ch_pop=0, out_write=0. After release: present_row=0, last_was_write=1; first grant is ch0 (C4 or C5).
- Row hit: present_row=0, last write; ch0 read at row 5, ch1 write at row 0 -> ch1 granted (C2). Next cycle ch0 granted, present_row=5.
- Urgency: ch2 usedw=201, new-row read, ch_urgent_en[2]=1; ch0 row-hit write -> ch2 granted. Repeat with ch_urgent_en[2]=0 -> ch0 granted.
- Round-robin: all 4 channels hold writes to row 0, refilled each cycle -> grant sequence 0,1,2,3,0,1.
- Starvation: MAX_WAIT=8; ch3 holds a new-row read, ch0 streams row-hit writes -> ch3 granted exactly on the 9th cycle after it becomes valid.
- Backpressure: out_full=1 for 10 cycles with ch1 valid -> no pops, wait_cnt[1] reaches min(10, MAX_WAIT). On deassert, ch1 is granted that cycle.
